// File: rtl/scroll_msg7seg.sv
// rtl/scroll_msg7seg.sv - scrolling message driver for a bank of active-low 7-segment digits
// Define SCROLL_BOUNCE_EN for ping-pong scrolling; the default build wraps around the buffer.
module scroll_msg7seg #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 16,
  parameter int TICK_DIV   = 16777216
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       run_i,
  input  logic                       dir_i,
  input  logic                       home_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr_i,
  input  logic [3:0]                 wr_data_i,
  output logic [7*NUM_DIGITS-1:0]    hex_o,
  output logic [$clog2(MSG_LEN)-1:0] pos_o,
  output logic                       tick_o
);
  localparam int PW = $clog2(MSG_LEN);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);

  logic [DW-1:0]           div_q, div_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [3:0]              msg_q [MSG_LEN];
  logic [3:0]              msg_d [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    tick;
  int                      win_idx;

  // Power-up message spells "HELLO" followed by blanks.
  function automatic logic [3:0] reset_char(input int k);
    case (k)
      0:       return 4'hA;
      1:       return 4'hB;
      2:       return 4'hC;
      3:       return 4'hC;
      4:       return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h09;
      4'hB:    return 7'h06;
      4'hC:    return 7'h47;
      4'hD:    return 7'h0C;
      4'hE:    return 7'h2F;
      default: return 7'h7F;
    endcase
  endfunction

  // home outranks the tick: a coinciding tick is swallowed entirely.
  assign tick = run_i && (div_q == DIV_LAST) && !home_i;

  always_comb begin
    div_d = div_q;
    if (home_i) begin
      div_d = '0;
    end else if (run_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

`ifdef SCROLL_BOUNCE_EN
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;
  localparam logic [PW-1:0] POS_MAX = PW'(MSG_LEN - NUM_DIGITS);

  dir_e dir_q, dir_d;
  logic unused_dir;
  assign unused_dir = dir_i;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (home_i) begin
      pos_d = '0;
      dir_d = DIR_LEFT;
    end else if (tick && (MSG_LEN > NUM_DIGITS)) begin
      if (dir_q == DIR_LEFT) begin
        if (pos_q == POS_MAX) begin
          pos_d = pos_q - PW'(1);
          dir_d = DIR_RIGHT;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d = PW'(1);
          dir_d = DIR_LEFT;
        end else begin
          pos_d = pos_q - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dir_q <= DIR_LEFT;
    else       dir_q <= dir_d;
  end
`else
  always_comb begin
    pos_d = pos_q;
    if (home_i) begin
      pos_d = '0;
    end else if (tick) begin
      if (!dir_i) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      else        pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < MSG_LEN; k++) msg_d[k] = msg_q[k];
    if (wr_en_i && (32'(wr_addr_i) < 32'(MSG_LEN))) msg_d[wr_addr_i] = wr_data_i;
  end

  // Offset never exceeds MSG_LEN-1, so one conditional subtract replaces the modulo.
  always_comb begin
    hex_d   = '1;
    win_idx = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      win_idx = int'(pos_q) + NUM_DIGITS - 1 - i;
      if (win_idx >= MSG_LEN) win_idx = win_idx - MSG_LEN;
      hex_d[7*i +: 7] = glyph(msg_q[PW'(win_idx)]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      pos_q <= '0;
      hex_q <= '1;
      for (int k = 0; k < MSG_LEN; k++) msg_q[k] <= reset_char(k);
    end else begin
      div_q <= div_d;
      pos_q <= pos_d;
      hex_q <= hex_d;
      for (int k = 0; k < MSG_LEN; k++) msg_q[k] <= msg_d[k];
    end
  end

  assign hex_o  = hex_q;
  assign pos_o  = pos_q;
  assign tick_o = tick;

endmodule

// File: tb/tb_scroll_msg7seg.sv
// tb/tb_scroll_msg7seg.sv - self-checking bench for scroll_msg7seg
// Reference model tracks message, position and divider with plain integer arithmetic.
module tb_scroll_msg7seg;
  localparam int ND = 8;
  localparam int ML = 16;
  localparam int TD = 4;
  localparam logic [55:0] BLANK = '1;
  localparam logic [55:0] HELLO = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [55:0] ELLO  = {7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        home = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic [55:0] hex;
  logic [3:0]  pos;
  logic        tick;

  int n_checks = 0;
  int n_fail = 0;

  int          m_msg [ML];
  int          m_pos;
  int          m_div;
  bit          m_right;
  logic [55:0] m_hex;

  // Lit segments per character code, by segment letter.
  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "bcefg", "adefg", "def", "abefg", "eg", ""};

  always #5 clk = ~clk;

  scroll_msg7seg #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .dir_i(dir), .home_i(home),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .hex_o(hex), .pos_o(pos), .tick_o(tick)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int c);
    logic [6:0] g;
    string s;
    g = 7'h7F;
    s = segs[c];
    for (int k = 0; k < s.len(); k++) g[int'(s[k]) - 97] = 1'b0;
    return g;
  endfunction

  function automatic logic [55:0] frame(input int p);
    logic [55:0] f;
    for (int i = 0; i < ND; i++) f[7*i +: 7] = glyph(m_msg[(p + ND - 1 - i) % ML]);
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ML; k++) m_msg[k] = 15;
    m_msg[0] = 10; m_msg[1] = 11; m_msg[2] = 12; m_msg[3] = 12; m_msg[4] = 0;
    m_pos = 0; m_div = 0; m_right = 1'b0; m_hex = BLANK;
  endtask

  task automatic advance();
`ifdef SCROLL_BOUNCE_EN
    if (ML > ND) begin
      if (!m_right) begin
        if (m_pos == ML - ND) begin m_pos = m_pos - 1; m_right = 1'b1; end
        else m_pos = m_pos + 1;
      end else begin
        if (m_pos == 0) begin m_pos = 1; m_right = 1'b0; end
        else m_pos = m_pos - 1;
      end
    end
`else
    m_pos = dir ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
`endif
  endtask

  task automatic cycle();
    logic exp_t;
    #1;
    exp_t = run && (m_div == TD - 1) && !home;
    check("tick", tick, exp_t);
    m_hex = frame(m_pos);
    if (home) begin
      m_div = 0; m_pos = 0; m_right = 1'b0;
    end else begin
      if (run) m_div = (m_div + 1) % TD;
      if (exp_t) advance();
    end
    if (wr_en && int'(wr_addr) < ML) m_msg[wr_addr] = int'(wr_data);
    @(posedge clk);
    #1;
    check("pos", pos, m_pos);
    check("hex", hex, m_hex);
  endtask

  // Reset is raised between edges and checked before the next edge arrives.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_pos", pos, 0);
    check("rst_hex", hex, BLANK);
    check("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int saved_pos;
    do_reset();
    run = 1'b1;
    cycle();
    check("first_frame", hex, HELLO);
    repeat (3) cycle();
    check("pos_after_first_tick", pos, 1);
    cycle();
    check("second_frame", hex, ELLO);

`ifndef SCROLL_BOUNCE_EN
    repeat (59) cycle();
    check("wrap_pos_zero", pos, 0);
    cycle();
    check("wrap_frame", hex, HELLO);
    dir = 1'b1;
    do_reset();
    repeat (4) cycle();
    check("right_pos", pos, 15);
    cycle();
    check("right_hex7_blank", hex[55:49], 7'h7F);
    check("right_hex6_h", hex[48:42], 7'h09);
    dir = 1'b0;
`else
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      repeat (4) cycle();
      check("bounce_pos", pos, (k <= 8) ? k : (k <= 16) ? 16 - k : k - 16);
    end
`endif

    run = 1'b0;
    saved_pos = m_pos;
    repeat (10) cycle();
    check("freeze_pos", pos, saved_pos);
    run = 1'b1;
    for (int k = 0; k < 8 && m_div != TD - 1; k++) cycle();
    home = 1'b1;
    cycle();
    check("home_pos", pos, 0);
    home = 1'b0;

    run = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd7;
    cycle();
    wr_en = 1'b0;
    check("write_not_yet", hex[20:14], 7'h7F);
    cycle();
    check("write_hex2", hex[20:14], 7'h78);

    for (int n = 0; n < 300; n++) begin
      run = ($urandom % 8) != 0;
      dir = $urandom % 2;
      home = ($urandom % 40) == 0;
      wr_en = ($urandom % 4) == 0;
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      cycle();
    end

    run = 1'b1; dir = 1'b0; home = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 100 && m_pos != 5; k++) cycle();
    check("pre_reset_pos", pos, 5);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
